// File: rtl/bullet_flight.sv
// bullet_flight: projectile sequencer for a tank shot, advanced once per video frame.
// Position is evaluated from latched launch operands and the externally supplied flight time.
module bullet_flight #(
    parameter int SCREEN_W = 640,
    parameter int GROUND_Y = 400,
    parameter int GRAV     = 1,
    parameter int COOLDOWN = 30
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic        fire_req,
    output logic        fire_ack,
    input  logic [9:0]  tank_x,
    input  logic [9:0]  tank_y,
    input  logic        dir_left,
    input  logic [3:0]  vx,
    input  logic [3:0]  vy,
    input  logic [63:0] time_in,
    output logic        drawbullflag,
    output logic        xbound,
    output logic [9:0]  bullet_x,
    output logic [9:0]  bullet_y,
    output logic        landed,
    output logic        busy
);
    localparam int W  = 24;
    localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    localparam logic signed [W-1:0] SCR_W  = W'(SCREEN_W);
    localparam logic signed [W-1:0] GND_Y  = W'(GROUND_Y);
    localparam logic signed [W-1:0] Y_SAT  = W'(1023);
    localparam logic        [W-1:0] GRAV_W = W'(GRAV);
    localparam logic [9:0]          X_MAX  = 10'(SCREEN_W - 1);
    localparam logic [9:0]          Y_GND  = 10'(GROUND_Y);
    localparam logic [CW-1:0]       CNT_LAST = CW'(COOLDOWN - 1);

    typedef enum logic [1:0] {IDLE, FLIGHT, BOUNCED, COOL} state_t;

    typedef struct packed {
        logic [9:0] x0;
        logic [9:0] y0;
        logic       dir;
        logic [3:0] sx;
        logic [3:0] sy;
    } launch_t;

    state_t  state, state_nxt;
    launch_t op;
    logic [CW-1:0] cnt;

    logic [7:0]          t;
    logic [W-1:0]        t_w, sxt_u, syt_u, grav_u;
    logic signed [W-1:0] x0_s, y0_s, xr, yr;
    logic                wall_lo, wall_hi, wall, ground, timeout, in_air;
    logic                launch, bounce, finish;
    logic [9:0]          x_clamp, y_clamp;
    logic                unused_time;

    assign unused_time = ^time_in[63:8];

    // All terms are widened before multiplying so no product wraps.
    assign t      = time_in[7:0];
    assign t_w    = W'(t);
    assign sxt_u  = W'(op.sx) * t_w;
    assign syt_u  = W'(op.sy) * t_w;
    assign grav_u = (GRAV_W * t_w * t_w) >> 1;
    assign x0_s   = $signed(W'(op.x0));
    assign y0_s   = $signed(W'(op.y0));
    assign xr     = op.dir ? (x0_s - $signed(sxt_u)) : (x0_s + $signed(sxt_u));
    assign yr     = y0_s - $signed(syt_u) + $signed(grav_u);

    assign wall_lo = xr[W-1];
    assign wall_hi = (xr >= SCR_W);
    assign wall    = wall_lo || wall_hi;
    assign ground  = (yr >= GND_Y);
    assign timeout = (t == 8'hFF);

    assign in_air       = (state == FLIGHT) || (state == BOUNCED);
    assign drawbullflag = in_air;
    assign busy         = (state != IDLE);

    always_comb begin
        x_clamp = xr[9:0];
        if (wall_lo)      x_clamp = '0;
        else if (wall_hi) x_clamp = X_MAX;
        y_clamp = yr[9:0];
        if (yr[W-1])        y_clamp = '0;
        else if (yr > Y_SAT) y_clamp = '1;
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Ground outranks everything, then timeout, then the wall; one bounce per flight.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        bounce    = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (fire_req) begin
                    launch    = 1'b1;
                    state_nxt = FLIGHT;
                end
            end
            FLIGHT, BOUNCED: begin
                if (ground || timeout) begin
                    finish = 1'b1;
                end else if (wall) begin
                    if (state == FLIGHT) begin
                        bounce    = 1'b1;
                        state_nxt = BOUNCED;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            COOL: begin
                if (cnt == CNT_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (finish) state_nxt = COOL;
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            op       <= '0;
            cnt      <= '0;
            fire_ack <= 1'b0;
            landed   <= 1'b0;
            xbound   <= 1'b0;
            bullet_x <= '0;
            bullet_y <= '0;
        end else begin
            fire_ack <= launch;
            landed   <= finish;

            if (launch) op <= {tank_x, tank_y, dir_left, vx, vy};
            if (bounce) begin
                op.x0  <= wall_lo ? 10'd0 : X_MAX;
                op.dir <= ~op.dir;
            end

            if (bounce)      xbound <= 1'b1;
            else if (finish) xbound <= 1'b0;

            if (in_air) begin
                bullet_x <= x_clamp;
                bullet_y <= ground ? Y_GND : y_clamp;
            end

            if (state == COOL && state_nxt == COOL) cnt <= cnt + 1'b1;
            else                                    cnt <= '0;
        end
    end
endmodule

// File: tb/tb_bullet_flight.sv
// Directed bench for bullet_flight: a GRAV=0 instance for straight/bounce shots and
// a GRAV=1 instance for arcs, both driven from the same launch inputs.
module tb_bullet_flight;
    logic        frame_clk;
    logic        Reset;
    logic        fire_req;
    logic [9:0]  tank_x, tank_y;
    logic        dir_left;
    logic [3:0]  vx, vy;
    logic [63:0] time_in;

    logic       ack0, draw0, xb0, land0, busy0;
    logic [9:0] bx0, by0;
    logic       ack1, draw1, xb1, land1, busy1;
    logic [9:0] bx1, by1;

    int errors = 0;
    int checks = 0;
    int ytab [10] = '{390, 386, 384, 382, 382, 382, 384, 386, 390, 394};

    bullet_flight #(.SCREEN_W(640), .GROUND_Y(400), .GRAV(0), .COOLDOWN(30)) u_g0 (
        .frame_clk(frame_clk), .Reset(Reset), .fire_req(fire_req), .fire_ack(ack0),
        .tank_x(tank_x), .tank_y(tank_y), .dir_left(dir_left), .vx(vx), .vy(vy),
        .time_in(time_in), .drawbullflag(draw0), .xbound(xb0),
        .bullet_x(bx0), .bullet_y(by0), .landed(land0), .busy(busy0)
    );

    bullet_flight #(.SCREEN_W(640), .GROUND_Y(400), .GRAV(1), .COOLDOWN(30)) u_g1 (
        .frame_clk(frame_clk), .Reset(Reset), .fire_req(fire_req), .fire_ack(ack1),
        .tank_x(tank_x), .tank_y(tank_y), .dir_left(dir_left), .vx(vx), .vy(vy),
        .time_in(time_in), .drawbullflag(draw1), .xbound(xb1),
        .bullet_x(bx1), .bullet_y(by1), .landed(land1), .busy(busy1)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic reset_pulse();
        Reset = 1'b0;
        time_in = '0;
        fire_req = 1'b0;
        #2;
        Reset = 1'b1;
    endtask

    task automatic setup(input int x, input int y, input int sx, input int sy, input logic d);
        tank_x   = 10'(x);
        tank_y   = 10'(y);
        vx       = 4'(sx);
        vy       = 4'(sy);
        dir_left = d;
    endtask

    initial begin
        Reset = 1'b0; fire_req = 1'b1; time_in = '0;
        setup(0, 0, 0, 0, 1'b0);

        // reset state, fire_req ignored while in reset
        #12;
        chk("rst_ack",  int'(ack0),  0);
        chk("rst_draw", int'(draw0), 0);
        chk("rst_xb",   int'(xb0),   0);
        chk("rst_bx",   int'(bx0),   0);
        chk("rst_by",   int'(by0),   0);
        chk("rst_land", int'(land0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_busy1", int'(busy1), 0);
        fire_req = 1'b0;
        Reset = 1'b1;

        // straight shot
        setup(100, 300, 4, 0, 1'b0);
        fire_req = 1'b1;
        tick();
        fire_req = 1'b0;
        chk("ss_ack",  int'(ack0),  1);
        chk("ss_draw", int'(draw0), 1);
        chk("ss_busy", int'(busy0), 1);
        for (int i = 0; i <= 10; i++) begin
            time_in = 64'(i);
            tick();
            chk("ss_bx", int'(bx0), 100 + 4 * i);
            chk("ss_by", int'(by0), 300);
            chk("ss_xb", int'(xb0), 0);
        end
        chk("ss_ack_once", int'(ack0), 0);
        reset_pulse();

        // handshake with fire_req held, timeout ending, 30-cycle cooldown
        setup(200, 200, 0, 0, 1'b0);
        fire_req = 1'b1;
        tick();
        chk("hs_ack1", int'(ack0), 1);
        tick();
        chk("hs_ack_flight", int'(ack0), 0);
        time_in = 64'd255;
        tick();
        chk("to_land", int'(land0), 1);
        chk("to_draw", int'(draw0), 0);
        chk("to_busy", int'(busy0), 1);
        chk("to_bx",   int'(bx0),   200);
        chk("to_by",   int'(by0),   200);
        for (int i = 1; i <= 29; i++) begin
            tick();
            chk("cool_busy", int'(busy0), 1);
            chk("cool_ack",  int'(ack0),  0);
        end
        chk("cool_land", int'(land0), 0);
        tick();
        chk("idle_busy", int'(busy0), 0);
        chk("idle_ack",  int'(ack0),  0);
        tick();
        chk("hs_ack2",  int'(ack0),  1);
        chk("hs_draw2", int'(draw0), 1);
        reset_pulse();

        // arc to ground (GRAV=1 instance)
        setup(300, 390, 0, 4, 1'b0);
        fire_req = 1'b1;
        tick();
        fire_req = 1'b0;
        chk("arc_ack", int'(ack1), 1);
        for (int i = 0; i <= 9; i++) begin
            time_in = 64'(i);
            tick();
            chk("arc_by",   int'(by1),   ytab[i]);
            chk("arc_draw", int'(draw1), 1);
        end
        time_in = 64'd10;
        tick();
        chk("arc_land", int'(land1), 1);
        chk("arc_draw_fall", int'(draw1), 0);
        chk("arc_by_gnd", int'(by1), 400);
        chk("arc_bx", int'(bx1), 300);
        tick();
        chk("arc_land_pulse", int'(land1), 0);
        chk("arc_cool_busy", int'(busy1), 1);
        reset_pulse();

        // wall bounce then second wall hit (GRAV=0 instance)
        setup(630, 100, 5, 0, 1'b0);
        fire_req = 1'b1;
        tick();
        fire_req = 1'b0;
        time_in = 64'd1;
        tick();
        chk("bn_bx1", int'(bx0), 635);
        chk("bn_xb0", int'(xb0), 0);
        time_in = 64'd2;
        tick();
        chk("bn_xb",   int'(xb0),   1);
        chk("bn_bx_clamp", int'(bx0), 639);
        chk("bn_draw", int'(draw0), 1);
        chk("bn_land", int'(land0), 0);
        time_in = 64'd1;
        tick();
        chk("bn_bx_back", int'(bx0), 634);
        chk("bn_xb_hold", int'(xb0), 1);
        time_in = 64'd50;
        tick();
        chk("bn_bx50", int'(bx0), 389);
        time_in = 64'd128;
        tick();
        chk("bn2_land", int'(land0), 1);
        chk("bn2_xb",   int'(xb0),   0);
        chk("bn2_bx",   int'(bx0),   0);
        chk("bn2_draw", int'(draw0), 0);
        reset_pulse();

        // asynchronous reset mid-flight
        setup(100, 100, 1, 0, 1'b0);
        fire_req = 1'b1;
        tick();
        fire_req = 1'b0;
        time_in = 64'd5;
        tick();
        chk("mr_bx", int'(bx0), 105);
        #2;
        Reset = 1'b0;
        #1;
        chk("mr_draw", int'(draw0), 0);
        chk("mr_busy", int'(busy0), 0);
        chk("mr_bx0",  int'(bx0),   0);
        chk("mr_by0",  int'(by0),   0);
        chk("mr_xb",   int'(xb0),   0);
        chk("mr_land", int'(land0), 0);
        #2;
        Reset = 1'b1;
        time_in = '0;
        tick();
        chk("mr_no_land", int'(land0), 0);
        fire_req = 1'b1;
        tick();
        fire_req = 1'b0;
        chk("mr_ack", int'(ack0), 1);
        chk("mr_land2", int'(land0), 0);
        tick();
        chk("mr_bx_new", int'(bx0), 100);
        reset_pulse();

        // ground and wall on the same edge (GRAV=1 instance)
        setup(630, 398, 5, 0, 1'b0);
        fire_req = 1'b1;
        tick();
        fire_req = 1'b0;
        time_in = 64'd1;
        tick();
        chk("gw_bx1", int'(bx1), 635);
        chk("gw_by1", int'(by1), 398);
        time_in = 64'd2;
        tick();
        chk("gw_land", int'(land1), 1);
        chk("gw_xb",   int'(xb1),   0);
        chk("gw_draw", int'(draw1), 0);
        chk("gw_by",   int'(by1),   400);
        chk("gw_bx",   int'(bx1),   639);
        tick();
        chk("gw_xb_after", int'(xb1), 0);
        chk("gw_cool", int'(busy1), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
